// File: rtl/and_or_exerciser.sv
// and_or_exerciser: sweeps all eight 3-bit patterns into an AND/OR reduction block and scores its responses.
module and_or_exerciser #(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             drv_1,
  output logic             drv_2,
  output logic             drv_3,
  input  logic             rsp_and,
  input  logic             rsp_or,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [7:0]       fail_vec
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [2:0] pattern;
  logic [3:0] cnt;
  logic mismatch;
  logic [ERR_W-1:0] err_next;
  always_comb begin
    mismatch = (rsp_and != &pattern) || (rsp_or != |pattern);
    err_next = (mismatch && !(&err_count)) ? err_count + ERR_W'(1) : err_count;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pattern <= '0;
      cnt <= '0;
      {drv_3, drv_2, drv_1} <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
      err_count <= '0;
      fail_vec <= '0;
    end else if (state != RUN) begin
      if (start) begin
        state <= RUN;
        pattern <= '0;
        cnt <= '0;
        {drv_3, drv_2, drv_1} <= '0;
        busy <= 1'b1;
        done <= 1'b0;
        pass <= 1'b0;
        err_count <= '0;
        fail_vec <= '0;
      end
    end else if (cnt != 4'(SETTLE_CYCLES)) begin
      cnt <= cnt + 4'd1;
    end else begin
      err_count <= err_next;
      if (mismatch) fail_vec[pattern] <= 1'b1;
      if (pattern != 3'd7) begin
        pattern <= pattern + 3'd1;
        cnt <= '0;
        {drv_3, drv_2, drv_1} <= pattern + 3'd1;
      end else begin
        state <= DONE;
        busy <= 1'b0;
        done <= 1'b1;
        pass <= (err_next == '0);
        {drv_3, drv_2, drv_1} <= '0;
      end
    end
  end
endmodule
